// File: rtl/retospect_pkg.sv
// Shared types and sizing helpers for the retospect configuration-chain loader.
package retospect_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 948;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_NN    = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Number of host bytes needed to carry len chain bits.
  function automatic int unsigned BYTES_PER_CHAIN(input int unsigned len);
    return (len + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/retospect_bs_packer.sv
// LSB-first serial-to-byte accumulator with a one-byte output register.
module retospect_bs_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       full_c,
  output logic       empty_c
);

  logic [7:0] acc;
  logic [2:0] pk_idx;

  // A new bit issued now would complete a byte that has nowhere to go.
  assign full_c  = out_valid && !out_ready &&
                   ((4'(pk_idx) + 4'(bit_valid)) >= 4'd7);
  assign empty_c = (pk_idx == 3'd0) && !out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      pk_idx    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (bit_valid) begin
        if (pk_idx == 3'd7) begin
          out_data  <= {bit_in, acc[6:0]};
          out_valid <= 1'b1;
          acc       <= '0;
          pk_idx    <= '0;
        end else begin
          acc[pk_idx] <= bit_in;
          pk_idx      <= pk_idx + 3'd1;
        end
      end else if (flush && (pk_idx != 3'd0) && (!out_valid || out_ready)) begin
        out_data  <= acc;
        out_valid <= 1'b1;
        acc       <= '0;
        pk_idx    <= '0;
      end
    end
  end

endmodule

// File: rtl/retospect_bs_loader.sv
// Shifts a host byte stream into the configuration chain and packs the
// bits leaving the chain into a readback byte stream.
module retospect_bs_loader
  import retospect_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter bit          PULSE_NN  = 1'b1,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       config_en,
  output logic       bs_in,
  input  logic       bs_out,
  output logic       nn_pulse,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NBYTES = BYTES_PER_CHAIN(CHAIN_LEN);
  localparam int unsigned BT_W   = $clog2(NBYTES + 1);

  state_e            state, state_nxt;
  logic [7:0]        holder;
  logic              holder_full;
  logic [2:0]        bit_idx;
  logic [BT_W-1:0]   bytes_taken;
  logic [CNT_W-1:0]  bit_cnt;
  logic              pk_full_c, pk_empty_c, pk_flush_c;
  logic              shift_fire_c, last_bit_c, in_hs_c;

  assign in_ready     = (state == ST_LOAD) && !holder_full &&
                        (bytes_taken < BT_W'(NBYTES));
  assign in_hs_c      = in_valid && in_ready;
  assign last_bit_c   = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign shift_fire_c = (state == ST_LOAD) && holder_full && !pk_full_c;
  // Partial byte is flushed only once the final in-flight bit has landed.
  assign pk_flush_c   = (state == ST_FLUSH) && !config_en;

  retospect_bs_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_valid (config_en),
    .bit_in    (bs_out),
    .flush     (pk_flush_c),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full_c    (pk_full_c),
    .empty_c   (pk_empty_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (shift_fire_c && last_bit_c) state_nxt = ST_FLUSH;
      ST_FLUSH: if (!config_en && pk_empty_c) state_nxt = PULSE_NN ? ST_NN : ST_FIN;
      ST_NN:    state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holder      <= '0;
      holder_full <= 1'b0;
      bit_idx     <= '0;
      bytes_taken <= '0;
      bit_cnt     <= '0;
      config_en   <= 1'b0;
      bs_in       <= 1'b0;
      nn_pulse    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      config_en <= shift_fire_c;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_FIN);
      nn_pulse  <= (state_nxt == ST_NN);
      if ((state == ST_IDLE) && start) begin
        holder_full <= 1'b0;
        bit_idx     <= '0;
        bytes_taken <= '0;
        bit_cnt     <= '0;
      end else if (in_hs_c) begin
        holder      <= in_data;
        holder_full <= 1'b1;
        bit_idx     <= '0;
        bytes_taken <= bytes_taken + BT_W'(1);
      end else if (shift_fire_c) begin
        bs_in   <= holder[bit_idx];
        bit_idx <= bit_idx + 3'd1;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if ((bit_idx == 3'd7) || last_bit_c) holder_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed bench: full 948-bit chain loader plus a 12-bit, no-pulse variant.
module tb_retospect_bs_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // Instance A: 948-bit chain, nn pulse enabled
  logic       a_rst_n, a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_config_en, a_bs_in, a_bs_out, a_nn_pulse, a_busy, a_done;
  logic [7:0] a_in_data, a_out_data;
  logic [947:0] a_chain = '0;

  // Instance B: 12-bit chain, nn pulse disabled
  logic       b_rst_n, b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic       b_config_en, b_bs_in, b_bs_out, b_nn_pulse, b_busy, b_done;
  logic [7:0] b_in_data, b_out_data;
  logic [11:0] b_chain = '0;

  logic [7:0] a_src  [0:118];
  logic [7:0] exp_rb [0:118];
  logic [947:0] snap;

  retospect_bs_loader #(.CHAIN_LEN(948), .PULSE_NN(1'b1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .start(a_start),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .config_en(a_config_en), .bs_in(a_bs_in), .bs_out(a_bs_out),
    .nn_pulse(a_nn_pulse), .busy(a_busy), .done(a_done)
  );

  retospect_bs_loader #(.CHAIN_LEN(12), .PULSE_NN(1'b0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .config_en(b_config_en), .bs_in(b_bs_in), .bs_out(b_bs_out),
    .nn_pulse(b_nn_pulse), .busy(b_busy), .done(b_done)
  );

  // Behavioural chains: bs_out is the bit leaving at the shifting edge.
  always @(posedge clk) if (a_config_en) a_chain <= {a_chain[946:0], a_bs_in};
  always @(posedge clk) if (b_config_en) b_chain <= {b_chain[10:0], b_bs_in};
  assign a_bs_out = a_chain[947];
  assign b_bs_out = b_chain[11];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_a(input bit gaps, input int stall_at, input int rst_at, input int lat_max);
    logic [7:0]   rb [0:118];
    logic [947:0] exp_chain;
    int idx, n, cfg, nn, dn, done_cyc, bad, k;
    bit fin, win;
    idx = 0; n = 0; cfg = 0; nn = 0; dn = 0; done_cyc = 0; bad = 0; fin = 1'b0;
    for (int j = 0; j < 119; j++) rb[j] = '0;
    @(negedge clk); a_start = 1'b1;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (a_nn_pulse) nn++;
      if (a_done) begin dn++; fin = 1'b1; done_cyc = cyc + 1; end
      if (a_config_en) begin
        cfg++;
        if (rst_at > 0 && cfg == rst_at) begin
          a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
          @(negedge clk); a_rst_n = 1'b1;
          check("rst_cfg_busy_ov", {a_config_en, a_busy, a_out_valid}, 3'b000);
          return;
        end
      end
      win = (stall_at > 0) && (cyc >= stall_at) && (cyc < stall_at + 20);
      if (stall_at > 0 && cyc == stall_at + 19) begin
        check("stall_config_en", a_config_en, 1'b0);
        check("stall_out_valid", a_out_valid, 1'b1);
      end
      a_in_valid = (idx < 119) && (!gaps || win || ($urandom_range(0, 3) != 0));
      a_in_data  = (idx < 119) ? a_src[idx] : 8'h00;
      if (a_in_valid && a_in_ready) idx++;
      a_out_ready = !win;
      if (a_out_valid && a_out_ready) begin
        if (n < 119) rb[n] = a_out_data;
        n++;
      end
    end
    check("a_done_seen", fin, 1'b1);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_done) dn++;
      if (a_nn_pulse) nn++;
    end
    check("a_config_en_cycles", cfg, 948);
    check("a_nn_pulses", nn, 1);
    check("a_done_pulses", dn, 1);
    check("a_busy_after", a_busy, 1'b0);
    check("a_rb_bytes", n, 119);
    if (lat_max > 0) check("a_latency_ok", done_cyc <= lat_max, 1'b1);
    for (int j = 0; j < 119; j++) if (rb[j] !== exp_rb[j]) bad++;
    check("a_rb_bad_bytes", bad, 0);
    check("a_rb_last", rb[118], exp_rb[118]);
    for (k = 0; k < 948; k++) exp_chain[947 - k] = a_src[k / 8][k % 8];
    check("a_chain_bad_bits", $countones(a_chain ^ exp_chain), 0);
  endtask

  task automatic run_b(input logic [7:0] e0, input logic [7:0] e1, input bit restart);
    logic [11:0] seq;
    logic [7:0] rb0, rb1;
    int cfg, n, taken, nn, dn;
    bit fin;
    seq = '0; rb0 = '0; rb1 = '0; cfg = 0; n = 0; taken = 0; nn = 0; dn = 0; fin = 1'b0;
    @(negedge clk); b_start = 1'b1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      b_start = restart && (cyc == 3);
      if (b_nn_pulse) nn++;
      if (b_done) begin dn++; fin = 1'b1; end
      if (b_config_en) begin
        if (cfg < 12) seq[4'(cfg)] = b_bs_in;
        cfg++;
      end
      b_in_valid = 1'b1;
      b_in_data  = (taken == 0) ? 8'h3C : (taken == 1) ? 8'h0E : 8'hFF;
      if (b_in_valid && b_in_ready) taken++;
      b_out_ready = 1'b1;
      if (b_out_valid) begin
        if (n == 0) rb0 = b_out_data;
        else if (n == 1) rb1 = b_out_data;
        n++;
      end
    end
    check("b_done_seen", fin, 1'b1);
    b_in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b_done) dn++;
      if (b_nn_pulse) nn++;
    end
    check("b_shift_seq", seq, 12'hE3C);
    check("b_config_en_cycles", cfg, 12);
    check("b_bytes_taken", taken, 2);
    check("b_rb_bytes", n, 2);
    check("b_rb0", rb0, e0);
    check("b_rb1", rb1, e1);
    check("b_nn_pulses", nn, 0);
    check("b_done_pulses", dn, 1);
    check("b_chain", b_chain, 12'h3C7);
  endtask

  initial begin
    a_rst_n = 1'b0; a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("a_reset_state", {a_busy, a_done, a_config_en, a_bs_in, a_nn_pulse,
                            a_out_valid, a_in_ready, a_out_data}, 15'h0);
    check("b_reset_state", {b_busy, b_done, b_config_en, b_bs_in, b_nn_pulse,
                            b_out_valid, b_in_ready, b_out_data}, 15'h0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);

    // Load all ones into an all-zero chain.
    for (int j = 0; j < 119; j++) begin a_src[j] = 8'hFF; exp_rb[j] = 8'h00; end
    run_a(1'b0, 0, 0, 2 * 119 + 948 + 4);

    // 0xA5 pattern returns the ones; last byte carries 4 bits.
    for (int j = 0; j < 119; j++) begin a_src[j] = 8'hA5; exp_rb[j] = 8'hFF; end
    exp_rb[118] = 8'h0F;
    run_a(1'b0, 0, 0, 0);

    // Random data with input gaps and a 20-cycle readback stall.
    for (int j = 0; j < 119; j++) begin a_src[j] = 8'($urandom); exp_rb[j] = 8'hA5; end
    exp_rb[118] = 8'h05;
    run_a(1'b1, 400, 0, 0);

    // Reset at bit 300, then a full reload.
    for (int j = 0; j < 119; j++) a_src[j] = 8'h3C;
    run_a(1'b0, 0, 300, 0);
    @(negedge clk);
    snap = a_chain;
    for (int j = 0; j < 119; j++) begin
      a_src[j] = 8'h5A;
      exp_rb[j] = '0;
      for (int b = 0; b < 8; b++)
        if (8 * j + b < 948) exp_rb[j][b] = snap[947 - (8 * j + b)];
    end
    run_a(1'b0, 0, 0, 0);

    // Short chain: partial last byte, then a reload with start pulsed mid-load.
    run_b(8'h00, 8'h00, 1'b0);
    run_b(8'h3C, 8'h0E, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
